// File: rtl/uart_alu_interface.sv
// -----------------------------------------------------------------------------
// uart_alu_interface
//
// Purpose:
//   Sequencer between uart_rx, an external ALU and uart_tx. Three received bytes
//   are collected in order (operand A, operand B, opcode) and presented to the
//   ALU. One cycle later the ALU result is latched and a single uart_tx transfer
//   is launched with it. A partial frame is discarded if the next byte does not
//   arrive within TIMEOUT_TICKS baud ticks.
//
// Ports:
//   clk           system clock
//   i_rst_n       asynchronous reset, active low
//   i_tick        baud oversample tick (1-cycle pulse)
//   i_rx_data     received byte, valid while i_rx_done=1
//   i_rx_done     1-cycle pulse per received byte
//   i_alu_result  combinational ALU result for o_data_a/o_data_b/o_op
//   i_tx_done     1-cycle pulse from uart_tx at the end of its stop bit
//   o_data_a      operand A to the ALU
//   o_data_b      operand B to the ALU
//   o_op          opcode to the ALU
//   o_tx_data     latched result byte to uart_tx
//   o_tx_start    1-cycle transfer request to uart_tx
//   o_busy        high in every state except IDLE
//   o_timeout     1-cycle pulse when a partial frame is discarded
//   o_overrun     1-cycle pulse when a byte arrives while a result is in flight
// -----------------------------------------------------------------------------
module uart_alu_interface #(
  parameter int NB_DATA       = 8,
  parameter int NB_OP         = 6,
  parameter int TIMEOUT_TICKS = 704,
  parameter int NB_TIMEOUT    = 10
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_B   = 3'd1,
    ST_WAIT_OP  = 3'd2,
    ST_EXEC     = 3'd3,
    ST_TX_START = 3'd4,
    ST_TX_WAIT  = 3'd5
  } state_t;

  // Count value at which the next tick expires the inter-byte window.
  localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(TIMEOUT_TICKS - 1);
  localparam logic [NB_TIMEOUT-1:0] CNT_ONE  = NB_TIMEOUT'(1);

  state_t                 state_q,    state_d;
  logic [NB_TIMEOUT-1:0]  cnt_q,      cnt_d;
  logic [NB_DATA-1:0]     data_a_q,   data_a_d;
  logic [NB_DATA-1:0]     data_b_q,   data_b_d;
  logic [NB_OP-1:0]       op_q,       op_d;
  logic [NB_DATA-1:0]     tx_data_q,  tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   busy_q,     busy_d;
  logic                   timeout_q,  timeout_d;
  logic                   overrun_q,  overrun_d;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Counter is held at zero while idle so every frame starts fresh.
        cnt_d = {NB_TIMEOUT{1'b0}};
        if (i_rx_done) begin
          data_a_d = i_rx_data;
          state_d  = ST_WAIT_B;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_WAIT_B, ST_WAIT_OP: begin
        // An arriving byte takes priority over a coincident terminal tick.
        if (i_rx_done) begin
          cnt_d = {NB_TIMEOUT{1'b0}};
          if (state_q == ST_WAIT_B) begin
            data_b_d = i_rx_data;
            state_d  = ST_WAIT_OP;
          end else begin
            op_d     = i_rx_data[NB_OP-1:0];
            state_d  = ST_EXEC;
          end
        end else if (i_tick) begin
          if (cnt_q == CNT_LAST) begin
            timeout_d = 1'b1;
            cnt_d     = {NB_TIMEOUT{1'b0}};
            state_d   = ST_IDLE;
          end else begin
            cnt_d     = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      ST_EXEC: begin
        // Operands have been stable on the ALU inputs for a full cycle here.
        tx_data_d = i_alu_result;
        overrun_d = i_rx_done;
        state_d   = ST_TX_START;
      end

      ST_TX_START: begin
        tx_start_d = 1'b1;
        overrun_d  = i_rx_done;
        state_d    = ST_TX_WAIT;
      end

      ST_TX_WAIT: begin
        overrun_d = i_rx_done;
        if (i_tx_done) begin
          cnt_d   = {NB_TIMEOUT{1'b0}};
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TX_WAIT;
        end
      end

      default: begin
        cnt_d   = {NB_TIMEOUT{1'b0}};
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {NB_TIMEOUT{1'b0}};
      data_a_q   <= {NB_DATA{1'b0}};
      data_b_q   <= {NB_DATA{1'b0}};
      op_q       <= {NB_OP{1'b0}};
      tx_data_q  <= {NB_DATA{1'b0}};
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_q;
  assign o_overrun  = overrun_q;

endmodule
